// File: rtl/restoring_divider_pkg.sv
// rtl/restoring_divider_pkg.sv - shared state encoding, output select and default width for the restoring divider
package restoring_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD1 = 4'd1,
        ST_LOAD2 = 4'd2,
        ST_LOAD3 = 4'd3,
        ST_CHECK = 4'd4,
        ST_ITER  = 4'd5,
        ST_OUT1  = 4'd6,
        ST_OUT2  = 4'd7,
        ST_OUT3  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        OSEL_NONE = 2'd0,
        OSEL_QHI  = 2'd1,
        OSEL_QLO  = 2'd2,
        OSEL_REM  = 2'd3
    } out_sel_t;

endpackage

// File: rtl/divider_state_machine.sv
// rtl/divider_state_machine.sv - sequencing FSM producing load/iterate/output strobes for the divider datapath
module divider_state_machine
    import restoring_divider_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    input  logic     divisor_zero,
    input  logic     last_iter,
    output logic     ld_hi,
    output logic     ld_lo,
    output logic     ld_div,
    output logic     check_en,
    output logic     iter_en,
    output out_sel_t out_sel,
    output logic     busy
);

    state_t state_q;
    state_t state_d;

    // State register; reset returns to Idle and abandons any division in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes; start is only looked at in Idle
    always_comb begin
        state_d  = state_q;
        ld_hi    = 1'b0;
        ld_lo    = 1'b0;
        ld_div   = 1'b0;
        check_en = 1'b0;
        iter_en  = 1'b0;
        out_sel  = OSEL_NONE;
        busy     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_LOAD1;
                end
            end
            ST_LOAD1: begin
                ld_hi   = 1'b1;
                state_d = ST_LOAD2;
            end
            ST_LOAD2: begin
                ld_lo   = 1'b1;
                state_d = ST_LOAD3;
            end
            ST_LOAD3: begin
                ld_div  = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                check_en = 1'b1;
                state_d  = divisor_zero ? ST_OUT1 : ST_ITER;
            end
            ST_ITER: begin
                iter_en = 1'b1;
                if (last_iter) begin
                    state_d = ST_OUT1;
                end
            end
            ST_OUT1: begin
                out_sel = OSEL_QHI;
                state_d = ST_OUT2;
            end
            ST_OUT2: begin
                out_sel = OSEL_QLO;
                state_d = ST_OUT3;
            end
            ST_OUT3: begin
                out_sel = OSEL_REM;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle restoring divider: 2W-bit dividend by W-bit divisor over a W-bit beat bus
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inBus,
    output logic [WIDTH-1:0] outBus,
    output logic             done,
    output logic             busy,
    output logic             divByZero
);

    localparam int CNT_W = $clog2(2 * WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);

    logic [2*WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]     r_q, r_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic     ld_hi, ld_lo, ld_div, check_en, iter_en;
    out_sel_t out_sel;
    logic     divisor_zero;
    logic     last_iter;

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           q_bit;

    assign divisor_zero = (divisor_q == '0);
    assign last_iter    = (cnt_q == CNT_LAST);

    divider_state_machine u_fsm (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .divisor_zero (divisor_zero),
        .last_iter    (last_iter),
        .ld_hi        (ld_hi),
        .ld_lo        (ld_lo),
        .ld_div       (ld_div),
        .check_en     (check_en),
        .iter_en      (iter_en),
        .out_sel      (out_sel),
        .busy         (busy)
    );

    // Datapath registers: D holds dividend then quotient, R the partial remainder
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_q       <= '0;
            r_q       <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else begin
            d_q       <= d_d;
            r_q       <= r_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
        end
    end

    // One restoring step per Iter cycle; the sign bit of the W+1 bit difference decides the quotient bit
    always_comb begin
        d_d       = d_q;
        r_d       = r_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        shifted   = {r_q[WIDTH-1:0], d_q[2*WIDTH-1]};
        diff      = shifted - {1'b0, divisor_q};
        q_bit     = ~diff[WIDTH];
        if (ld_hi) begin
            d_d[2*WIDTH-1:WIDTH] = inBus;
        end
        if (ld_lo) begin
            d_d[WIDTH-1:0] = inBus;
        end
        if (ld_div) begin
            divisor_d = inBus;
            r_d       = '0;
            cnt_d     = '0;
        end
        // Divide-by-zero skips Iter and reports an all-ones quotient with zero remainder
        if (check_en && divisor_zero) begin
            d_d = '1;
            r_d = '0;
        end
        if (iter_en) begin
            r_d   = q_bit ? diff : shifted;
            d_d   = {d_q[2*WIDTH-2:0], q_bit};
            cnt_d = last_iter ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Result beat mux, high quotient beat first; bus is quiet outside the output states
    always_comb begin
        outBus = '0;
        done   = 1'b1;
        case (out_sel)
            OSEL_QHI: outBus = d_q[2*WIDTH-1:WIDTH];
            OSEL_QLO: outBus = d_q[WIDTH-1:0];
            OSEL_REM: outBus = r_q[WIDTH-1:0];
            default:  done   = 1'b0;
        endcase
        divByZero = done & divisor_zero;
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - randomized and directed self-checking bench for restoring_divider
module tb_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] inBus = '0;
    logic [W-1:0] outBus;
    logic         done;
    logic         busy;
    logic         divByZero;

    int n_vec  = 0;
    int n_miss = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inBus     (inBus),
        .outBus    (outBus),
        .done      (done),
        .busy      (busy),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one division starting at cycle 0 and checks every cycle up to the Idle after Out3.
    // abort_at > 0 pulls reset low during that cycle; everything after must stay quiet.
    task automatic run_div(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [W-1:0] dv,
                           input bit hold, input int abort_at);
        logic [2*W-1:0] dividend;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic [W-1:0]   exp_out;
        bit             dbz;
        bit             aborted;
        bit             exp_done;
        bit             exp_busy;
        int             o1;
        dividend = {hi, lo};
        dbz = (dv == 0);
        if (dbz) begin
            q = '1;
            r = '0;
        end else begin
            q = dividend / {{W{1'b0}}, dv};
            r = W'(dividend % {{W{1'b0}}, dv});
        end
        o1 = dbz ? 5 : 5 + 2 * W;

        @(posedge clk); #1;
        start = 1'b1;
        inBus = W'($urandom);
        @(negedge clk);
        check_eq($sformatf("c0_busy %h%h/%h", hi, lo, dv), busy, 0);
        check_eq($sformatf("c0_done %h%h/%h", hi, lo, dv), done, 0);

        for (int c = 1; c <= o1 + 3; c++) begin
            @(posedge clk); #1;
            aborted = (abort_at > 0) && (c > abort_at);
            start = hold && !aborted;
            rst = !(abort_at > 0 && c == abort_at);
            case (c)
                1: inBus = hi;
                2: inBus = lo;
                3: inBus = dv;
                default: inBus = W'($urandom);
            endcase
            @(negedge clk);
            exp_done = !aborted && c >= o1 && c <= o1 + 2;
            exp_busy = !aborted && c < o1 + 3;
            exp_out  = '0;
            if (exp_done) begin
                if (c == o1)          exp_out = q[2*W-1:W];
                else if (c == o1 + 1) exp_out = q[W-1:0];
                else                  exp_out = r;
            end
            check_eq($sformatf("done c%0d %h%h/%h", c, hi, lo, dv), done, exp_done);
            check_eq($sformatf("busy c%0d %h%h/%h", c, hi, lo, dv), busy, exp_busy);
            check_eq($sformatf("out c%0d %h%h/%h", c, hi, lo, dv), outBus, exp_out);
            check_eq($sformatf("dbz c%0d %h%h/%h", c, hi, lo, dv), divByZero, exp_done && dbz);
        end

        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        // A held start relaunches from Idle; clear that run with a reset pulse
        if (hold) begin
            rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out", outBus, 0);
        check_eq("rst_dbz", divByZero, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_div(8'h03, 8'hE8, 8'h07, 1'b0, 0);
        run_div(8'hFF, 8'hFF, 8'hFF, 1'b0, 0);
        run_div(8'h00, 8'h05, 8'h09, 1'b0, 0);
        run_div(8'h12, 8'h34, 8'h00, 1'b0, 0);
        run_div(8'hFF, 8'hFF, 8'h01, 1'b1, 0);
        run_div(8'h12, 8'h34, 8'h56, 1'b0, 10);
        run_div(8'h00, 8'h64, 8'h0A, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] rh, rl, rd;
            rh = W'($urandom);
            rl = W'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_div(rh, rl, rd, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
